// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, FSM states
// and the default datapath width.
package mdu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // rem_in < divisor always holds, so the difference fits in WIDTH bits
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted[WIDTH-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding HI/LO; one shift-add or restoring-divide
// iteration per cycle on operand magnitudes, sign fixed up in a final cycle.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             is_div, div0, neg_res, neg_rem;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic             in_signed, in_div, in_div0, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    in_signed = (op == OP_MULT) || (op == OP_DIV);
    in_div    = (op == OP_DIV) || (op == OP_DIVU);
    in_div0   = in_div && (op_b == '0);
    a_neg     = in_signed & op_a[WIDTH-1];
    b_neg     = in_signed & op_b[WIDTH-1];
    mag_a     = a_neg ? -op_a : op_a;
    mag_b     = b_neg ? -op_b : op_b;
  end

  // Multiply: acc_lo holds the multiplier shifting out, product accumulates in {acc_hi, acc_lo}
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
  end

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc_hi),
    .bit_in  (acc_lo[WIDTH-1]),
    .divisor (opnd),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = in_div0 ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            is_div  <= in_div;
            div0    <= in_div0;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            opnd    <= in_div ? mag_b : mag_a;
            acc_hi  <= '0;
            // divide-by-zero keeps the raw dividend so HI can return it unchanged
            acc_lo  <= in_div ? (in_div0 ? op_a : mag_a) : mag_b;
          end else begin
            if (mthi) hi <= op_a;
            if (mtlo) lo <= op_a;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= rem_nxt;
            acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (div0) begin
            hi <= acc_lo;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: table of operations with a result scoreboard,
// plus hand-written sequences for mid-operation start/reset and mthi/mtlo.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        tbl[12];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // mode 0: plain; 1: second start mid-op; 2: mtlo while busy; 3: start together with mtlo
  task automatic run_op(input vec_t v, input int mode);
    exp_t e;
    int   n;
    logic bad_busy;
    @(negedge clk);
    op = v.op; op_a = v.a; op_b = v.b; start = 1'b1;
    mtlo = (mode == 3);
    sb.push_back('{hi: v.hi, lo: v.lo});
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0; n = 0;
    bad_busy = !busy;
    if (mode == 3) chk("start_wins_mtlo", lo, m_lo);
    while (!done && n < 200) begin
      start = (mode == 1 && n == 10);
      if (start) begin op = OP_DIVU; op_a = 32'd99; op_b = 32'd3; end
      mtlo = (mode == 2 && n == 5);
      if (mtlo) op_a = 32'h1234_5678;
      @(posedge clk); #1;
      n++;
      if (mode == 2 && n == 6) chk("mtlo_while_busy", lo, m_lo);
      if (!done && !busy) bad_busy = 1'b1;
    end
    start = 1'b0; mtlo = 1'b0;
    chk("latency", 32'(n), 32'(v.lat));
    chk("busy_window", {31'd0, bad_busy}, 32'd0);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      m_hi = e.hi; m_lo = e.lo;
    end else begin
      chk("done_seen", {31'd0, done}, 32'd1);
    end
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   seen;
    vec_t v;
    tbl[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
    tbl[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    tbl[2]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
    tbl[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    tbl[5]  = '{OP_DIV,   32'd123,       32'd0,        32'd123,       32'hFFFF_FFFF, 1};
    tbl[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
    tbl[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 33};
    tbl[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    tbl[9]  = '{OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
    tbl[10] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 1};
    tbl[11] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};

    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(tbl[i], 0);

    // second start mid-operation is ignored
    v = '{OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 33};
    run_op(v, 1);
    // mtlo while busy is ignored
    v = '{OP_DIVU, 32'd1000, 32'd9, 32'd1, 32'd111, 33};
    run_op(v, 2);
    // start wins over a simultaneous mtlo
    v = '{OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33};
    run_op(v, 3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // mthi in IDLE, then mthi+mtlo together
    @(negedge clk); mthi = 1'b1; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1; mthi = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, m_lo);
    chk("mthi_no_done", {31'd0, done}, 32'd0);
    m_hi = 32'hDEAD_BEEF;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; op_a = 32'h0BAD_F00D;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'h0BAD_F00D);
    chk("mt_both_lo", lo, 32'h0BAD_F00D);
    m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;

    // asynchronous reset in the middle of MULT 6x7
    @(negedge clk); op = OP_MULT; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // unit recovers after reset
    run_op(tbl[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
